fm_mod_sample_pacer: RTL and testbench

FM_MOD_SAMPLE_PACER -- requirements
Module: fm_mod_sample_pacer

---
 rtl/fm_mod_sample_pacer.sv | 151 +++++++++++++++
 tb/tb_fm_mod_sample_pacer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_mod_sample_pacer.sv
// fm_mod_sample_pacer
//   Paces ADC conversions for the FM modulator: every CLK_DIV cycles it
//   issues an SOC pulse, waits (bounded) for EOC, captures ADC_DATA and
//   strobes sample_valid. Missing EOCs and dropped sample ticks raise
//   sticky error flags.
//
// Ports
//   CLK          system clock, rising edge
//   RST          synchronous active-high reset
//   FM_mod_en    pacing enable (sync to CLK); low forces IDLE
//   EOC          ADC end-of-conversion, asynchronous, active-high
//   ADC_DATA     ADC result, stable while EOC is high
//   err_clr      single-cycle clear of the sticky flags
//   SOC          ADC start-of-conversion pulse (SOC_W cycles)
//   sample_out   last captured sample
//   sample_valid one-cycle strobe when sample_out updates
//   timeout_err  sticky: EOC did not arrive in time
//   overrun_err  sticky: a sample tick was dropped
module fm_mod_sample_pacer #(
  parameter int CLK_DIV     = 2500,
  parameter int SOC_W       = 4,
  parameter int EOC_TIMEOUT = 1000,
  parameter int DATA_W      = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FM_mod_en,
  input  logic              EOC,
  input  logic [DATA_W-1:0] ADC_DATA,
  input  logic              err_clr,
  output logic              SOC,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              timeout_err,
  output logic              overrun_err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_TICK = 3'd1;
  localparam logic [2:0] SOC_PULSE = 3'd2;
  localparam logic [2:0] WAIT_EOC  = 3'd3;
  localparam logic [2:0] CAPTURE   = 3'd4;

  localparam int PW = $clog2(CLK_DIV);
  localparam int TW = $clog2(EOC_TIMEOUT);

  logic [2:0]    state;
  logic [PW-1:0] per_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    soc_cnt;
  logic          sync1, sync2, sync2_d;
  logic          tick, eoc_rise, to_hit;

  assign tick     = (per_cnt == PW'(CLK_DIV - 1));
  assign eoc_rise = sync2 & ~sync2_d;
  assign to_hit   = (to_cnt == TW'(EOC_TIMEOUT - 1));

  // EOC is asynchronous: two-flop synchronizer plus one delay stage for
  // the rising-edge detect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= EOC;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  // Sample-period counter. Held at 0 while disabled and while still in
  // IDLE, so the first period after enabling is a full CLK_DIV cycles
  // measured from the WAIT_TICK entry.
  always_ff @(posedge CLK) begin
    if (RST || !FM_mod_en || state == IDLE) begin
      per_cnt <= '0;
    end else if (tick) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      to_cnt       <= '0;
      soc_cnt      <= '0;
      SOC          <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      // Clear first; any set below in the same cycle overrides it.
      if (err_clr) begin
        timeout_err <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (!FM_mod_en) begin
        // Abort whatever is in flight; sample_out and flags are kept.
        state   <= IDLE;
        SOC     <= 1'b0;
        to_cnt  <= '0;
        soc_cnt <= '0;
      end else begin
        // Only WAIT_TICK can consume a tick; anywhere else it is lost.
        if (tick && state != WAIT_TICK) overrun_err <= 1'b1;
        case (state)
          IDLE: state <= WAIT_TICK;
          WAIT_TICK: begin
            if (tick) begin
              state   <= SOC_PULSE;
              SOC     <= 1'b1;
              soc_cnt <= '0;
            end
          end
          SOC_PULSE: begin
            if (soc_cnt == 4'(SOC_W - 1)) begin
              state  <= WAIT_EOC;
              SOC    <= 1'b0;
              to_cnt <= '0;
            end else begin
              soc_cnt <= soc_cnt + 1'b1;
            end
          end
          WAIT_EOC: begin
            // eoc_rise is tested first so it beats a coincident timeout.
            if (eoc_rise) begin
              state <= CAPTURE;
            end else if (to_hit) begin
              state       <= WAIT_TICK;
              timeout_err <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          CAPTURE: begin
            sample_out   <= ADC_DATA;
            sample_valid <= 1'b1;
            state        <= WAIT_TICK;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fm_mod_sample_pacer.sv
// Bench for fm_mod_sample_pacer. A randomized ADC model reacts to each SOC
// falling edge with a random EOC delay and data; the expected outcome
// (capture with data and cycle, or timeout cycle) is pushed into a
// scoreboard queue and a separate monitor pops it when the DUT reports.
// A second instance with a short period checks the overrun behaviour.
module tb_fm_mod_sample_pacer;
  localparam int DIV = 20;
  localparam int SW  = 2;
  localparam int TO  = 8;
  localparam int DW  = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, eoc, err_clr;
  logic [DW-1:0] adc_data, sout;
  logic          soc, sv, to_err, ov_err;

  logic          rst2, en2, eoc2, clr2;
  logic [DW-1:0] adc2, sout2;
  logic          soc2, sv2, to2, ov2;

  fm_mod_sample_pacer #(.CLK_DIV(DIV), .SOC_W(SW), .EOC_TIMEOUT(TO), .DATA_W(DW)) dut (
    .CLK(clk), .RST(rst), .FM_mod_en(en), .EOC(eoc), .ADC_DATA(adc_data),
    .err_clr(err_clr), .SOC(soc), .sample_out(sout), .sample_valid(sv),
    .timeout_err(to_err), .overrun_err(ov_err));

  fm_mod_sample_pacer #(.CLK_DIV(16), .SOC_W(2), .EOC_TIMEOUT(20), .DATA_W(DW)) dut_ov (
    .CLK(clk), .RST(rst2), .FM_mod_en(en2), .EOC(eoc2), .ADC_DATA(adc2),
    .err_clr(clr2), .SOC(soc2), .sample_out(sout2), .sample_valid(sv2),
    .timeout_err(to2), .overrun_err(ov2));

  typedef struct {
    bit cap;
    int data;
    int when;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int conv = 0;
  bit adc_on = 0, adc_busy = 0, per_chk = 0, ov_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not allowed here (cycle %0d)", name, cyc);
  endtask

  // ADC model: on SOC fall, choose delay d (9 = never) and data.
  initial begin
    bit ps;
    int f, d, dat;
    ps = 0;
    eoc = 0; adc_data = '0; err_clr = 0;
    forever begin
      @(posedge clk); #1;
      if (adc_on && ps && !soc) begin
        adc_busy = 1;
        f = cyc;
        case (conv)
          0: d = 3;
          1: d = 5;   // rise detected on the last timeout cycle
          2: d = 9;   // never
          3: d = 6;   // one cycle too late
          default: d = $urandom_range(0, 9);
        endcase
        dat = (conv == 0) ? 'hA5C : $urandom_range(0, 4095);
        conv++;
        // EOC first sampled at F+d+1; captured data appears 3 edges later.
        // The rise is seen by the FSM at F+d+3, which must not exceed F+TO.
        if (d <= TO - 3) sb.push_back('{1'b1, dat, f + d + 4});
        else             sb.push_back('{1'b0, 0, f + TO});
        if (d != 9) begin
          repeat (d) @(posedge clk);
          @(negedge clk); eoc = 1; adc_data = dat[DW-1:0];
          repeat (4) @(posedge clk);
          @(negedge clk); eoc = 0;
        end
        if (d > TO - 3) begin
          while (cyc < f + TO + 1) begin @(posedge clk); #1; end
          @(negedge clk); err_clr = 1;
          @(posedge clk); #1; err_clr = 0;
          check("err_clr_timeout", to_err, 0);
        end
        adc_busy = 0;
      end
      ps = soc;
    end
  end

  // Monitor: scoreboard pops, SOC timing, sample_out hold.
  initial begin
    bit pto, psoc;
    int last_rise, rise_at;
    logic [DW-1:0] last_cap;
    exp_t e;
    pto = 0; psoc = 0; last_rise = -1; rise_at = 0; last_cap = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) last_cap = '0;
      if (sv) begin
        if (sb.size() == 0) fail("unexpected_valid");
        else begin
          e = sb.pop_front();
          check("valid_kind", e.cap, 1);
          check("valid_data", sout, e.data);
          check("valid_cycle", cyc, e.when);
        end
        last_cap = sout;
      end else if (!rst) begin
        if (sout !== last_cap) check("sample_hold", sout, last_cap);
      end
      if (to_err && !pto) begin
        if (sb.size() == 0) fail("unexpected_timeout");
        else begin
          e = sb.pop_front();
          check("timeout_kind", e.cap, 0);
          check("timeout_cycle", cyc, e.when);
        end
      end
      if (!per_chk) last_rise = -1;
      if (soc && !psoc) begin
        if (per_chk && last_rise >= 0) check("soc_period", cyc - last_rise, DIV);
        last_rise = cyc;
        rise_at = cyc;
      end
      if (!soc && psoc && per_chk) check("soc_width", cyc - rise_at, SW);
      pto = to_err;
      psoc = soc;
    end
  end

  // Overrun instance: CLK_DIV=16, EOC_TIMEOUT=20, EOC never arrives.
  initial begin
    int r[6];
    int g;
    rst2 = 1; en2 = 0; eoc2 = 0; adc2 = '0; clr2 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst2 = 0; en2 = 1;
    for (int i = 0; i < 6; i++) begin
      g = 0;
      while (soc2 && g < 80) begin @(posedge clk); #1; g++; end
      while (!soc2 && g < 80) begin @(posedge clk); #1; g++; end
      if (g >= 80) fail("ov_soc_missing");
      r[i] = cyc;
      if (i == 4) begin
        check("ov_flag_set", ov2, 1);
        check("ov_timeout_set", to2, 1);
        while (cyc < r[4] + 24) begin @(posedge clk); #1; end
        @(negedge clk); clr2 = 1;
        @(posedge clk); #1; clr2 = 0;
        check("ov_clr_overrun", ov2, 0);
        check("ov_clr_timeout", to2, 0);
      end
    end
    for (int i = 1; i < 6; i++) check("ov_soc_period", r[i] - r[i-1], 32);
    // Clear lands on the same edge as the dropped tick: set must win.
    while (cyc < r[5] + 15) begin @(posedge clk); #1; end
    @(negedge clk); clr2 = 1;
    @(posedge clk); #1; clr2 = 0;
    check("ov_set_wins", ov2, 1);
    check("ov_sv_never", sv2, 0);
    ov_done = 1;
  end

  // Main sequence.
  initial begin
    int g, c0;
    logic [DW-1:0] so;
    rst = 1; en = 0;
    repeat (3) @(posedge clk); #1;
    check("rst_soc", soc, 0);
    check("rst_sample_out", sout, 0);
    check("rst_valid", sv, 0);
    check("rst_timeout", to_err, 0);
    check("rst_overrun", ov_err, 0);
    @(negedge clk); rst = 0;
    adc_on = 1; per_chk = 1;
    @(negedge clk); en = 1;

    g = 0;
    while (!(conv >= 24 && !adc_busy) && g < 2000) begin @(negedge clk); g++; end
    if (g >= 2000) fail("conversion_progress");
    adc_on = 0;
    check("sb_empty", sb.size(), 0);
    check("no_overrun", ov_err, 0);

    // Disable during the first SOC cycle, then re-enable.
    per_chk = 0;
    g = 0;
    @(posedge clk); #1;
    while (!soc && g < 40) begin @(posedge clk); #1; g++; end
    if (g >= 40) fail("dis_soc_missing");
    so = sout;
    @(negedge clk); en = 0;
    @(posedge clk); #1;
    check("dis_soc_low", soc, 0);
    check("dis_sample_hold", sout, so);
    repeat (5) @(posedge clk); #1;
    check("dis_idle_soc", soc, 0);
    @(negedge clk); en = 1; c0 = cyc;
    g = 0;
    @(posedge clk); #1;
    while (!soc && g < 40) begin @(posedge clk); #1; g++; end
    check("reenable_delay", cyc - c0, 21);

    // Reset while waiting for EOC.
    g = 0;
    while (soc && g < 10) begin @(posedge clk); #1; g++; end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1; en = 0;
    @(posedge clk); #1;
    check("rst_mid_soc", soc, 0);
    check("rst_mid_sample_out", sout, 0);
    check("rst_mid_valid", sv, 0);
    check("rst_mid_timeout", to_err, 0);
    check("rst_mid_overrun", ov_err, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (20) @(posedge clk); #1;
    check("post_rst_timeout", to_err, 0);

    g = 0;
    while (!ov_done && g < 1000) begin @(posedge clk); g++; end
    if (!ov_done) fail("overrun_instance_done");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
